// File: rtl/lcd_write_sequencer_if.sv
// Bundles the upstream byte stream and the Avalon-MM link to the LCD slave.
//   in_valid/in_ready/in_rs/in_data : byte handshake from the producer
//   avm_address/avm_write/avm_read  : LCD access strobes (address bit1 = RS, bit0 = RW)
//   avm_begintransfer               : first cycle of each access
//   avm_writedata/avm_readdata      : byte to LCD / LCD status (bit7 = busy flag)
// master: the sequencer (Avalon master, stream sink); slave: its environment.
interface lcd_write_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic [1:0] avm_address;
    logic       avm_write;
    logic       avm_read;
    logic       avm_begintransfer;
    logic [7:0] avm_writedata;
    logic [7:0] avm_readdata;

    modport master (
        input  in_valid, in_rs, in_data, avm_readdata,
        output in_ready, avm_address, avm_write, avm_read, avm_begintransfer, avm_writedata
    );

    modport slave (
        output in_valid, in_rs, in_data, avm_readdata,
        input  in_ready, avm_address, avm_write, avm_read, avm_begintransfer, avm_writedata
    );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Queues LCD command/data bytes and replays each one as a timed write access
// followed by busy-flag polling reads until the LCD reports ready.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : lcd_write_sequencer_if.master (byte stream in, Avalon-MM to LCD out)
//   busy        : FIFO non-empty or an access sequence in flight
//   timeout_err : sticky, set when a byte exhausts POLL_LIMIT busy polls
module lcd_write_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned E_CYCLES   = 12,
    parameter int unsigned GAP_CYCLES = 25,
    parameter int unsigned POLL_LIMIT = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_write_sequencer_if.master bus,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PhaseMax = (E_CYCLES > GAP_CYCLES) ? E_CYCLES : GAP_CYCLES;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
    localparam int unsigned PollW    = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {StIdle, StWr, StWgap, StPoll, StPgap} state_e;

    state_e            state_q;
    logic [PhaseW-1:0] phase_q;   // cycles left in the current state, minus one
    logic [PollW-1:0]  poll_q;    // busy-flag reads issued for the current byte
    logic              flag_q;    // busy flag captured on the last poll cycle

    // FIFO entries hold {rs, data}
    logic [8:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic            fifo_push;
    logic            fifo_pop;
    logic [8:0]      fifo_head;

    logic unused_readdata;
    assign unused_readdata = ^bus.avm_readdata[6:0];

    // in_ready depends only on the registered count, so a pop never bypasses into a push
    assign bus.in_ready = (fifo_cnt_q != CntW'(FIFO_DEPTH));
    assign fifo_push    = bus.in_valid && bus.in_ready;
    assign fifo_pop     = (state_q == StIdle) && (fifo_cnt_q != '0);
    assign fifo_head    = mem[rd_ptr_q];
    assign busy         = (state_q != StIdle) || (fifo_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr_q] <= {bus.in_rs, bus.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= StIdle;
            phase_q               <= '0;
            poll_q                <= '0;
            flag_q                <= 1'b0;
            timeout_err           <= 1'b0;
            bus.avm_write         <= 1'b0;
            bus.avm_read          <= 1'b0;
            bus.avm_begintransfer <= 1'b0;
            bus.avm_address       <= 2'b00;
            bus.avm_writedata     <= 8'h00;
        end else begin
            bus.avm_begintransfer <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        state_q               <= StWr;
                        phase_q               <= PhaseW'(E_CYCLES - 1);
                        bus.avm_write         <= 1'b1;
                        bus.avm_begintransfer <= 1'b1;
                        bus.avm_address       <= {fifo_head[8], 1'b0};
                        bus.avm_writedata     <= fifo_head[7:0];
                    end
                end
                StWr: begin
                    if (phase_q == '0) begin
                        state_q         <= StWgap;
                        phase_q         <= PhaseW'(GAP_CYCLES - 1);
                        bus.avm_write   <= 1'b0;
                        bus.avm_address <= 2'b00;
                    end else begin
                        phase_q <= phase_q - PhaseW'(1);
                    end
                end
                StWgap: begin
                    if (phase_q == '0) begin
                        state_q               <= StPoll;
                        phase_q               <= PhaseW'(E_CYCLES - 1);
                        poll_q                <= '0;
                        bus.avm_read          <= 1'b1;
                        bus.avm_begintransfer <= 1'b1;
                        bus.avm_address       <= 2'b01;
                    end else begin
                        phase_q <= phase_q - PhaseW'(1);
                    end
                end
                StPoll: begin
                    if (phase_q == '0) begin
                        state_q         <= StPgap;
                        phase_q         <= PhaseW'(GAP_CYCLES - 1);
                        flag_q          <= bus.avm_readdata[7];
                        poll_q          <= poll_q + PollW'(1);
                        bus.avm_read    <= 1'b0;
                        bus.avm_address <= 2'b00;
                    end else begin
                        phase_q <= phase_q - PhaseW'(1);
                    end
                end
                StPgap: begin
                    if (phase_q == '0) begin
                        if (!flag_q) begin
                            state_q <= StIdle;
                        end else if (poll_q < PollW'(POLL_LIMIT)) begin
                            state_q               <= StPoll;
                            phase_q               <= PhaseW'(E_CYCLES - 1);
                            bus.avm_read          <= 1'b1;
                            bus.avm_begintransfer <= 1'b1;
                            bus.avm_address       <= 2'b01;
                        end else begin
                            // Give up on this byte; carry on with the queue
                            timeout_err <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end else begin
                        phase_q <= phase_q - PhaseW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: directed byte pushes with a per-byte busy-poll
// script, a timeline model of the expected LCD bus activity, and literal checks.
module tb_lcd_write_sequencer;
    localparam int DEPTH  = 8;
    localparam int E      = 12;
    localparam int G      = 25;
    localparam int PLIM   = 4;
    localparam int BUDGET = 2000;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         nbusy;   // polls that report busy before the LCD is ready
    } item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic timeout_err;

    lcd_write_sequencer_if bus ();

    lcd_write_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .E_CYCLES  (E),
        .GAP_CYCLES(G),
        .POLL_LIMIT(PLIM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    bit chk_en     = 1'b0;
    int stim_nbusy = 0;

    // Model: queue of pending bytes plus the timeline of the byte in service
    item_t      mq[$];
    bit         m_active     = 1'b0;
    int         seg_start    = 0;
    int         n_polls      = 0;
    int         m_nbusy      = 0;
    bit         m_to_pending = 1'b0;
    logic       m_rs         = 1'b0;
    logic [7:0] m_wdata      = 8'h00;
    bit         m_timeout    = 1'b0;

    // Monitor
    int         mon_wr        = 0;
    int         mon_rd        = 0;
    int         mon_bt        = 0;
    int         mon_wr_bt_cyc = -1;
    int         mon_rd_bt_cyc = -1;
    logic [1:0] mon_wr_addr   = 2'b00;
    logic [7:0] mon_wr_data   = 8'h00;
    logic [7:0] mon_wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge
    task automatic model_edge();
        bit    accept;
        item_t it;
        if (reset) begin
            mq.delete();
            m_active     = 1'b0;
            m_timeout    = 1'b0;
            m_to_pending = 1'b0;
            m_wdata      = 8'h00;
        end else begin
            accept = (bus.in_valid === 1'b1) && (mq.size() < DEPTH);
            if (m_active) begin
                // Byte occupies write+gap plus n_polls*(read+gap) cycles
                if (cyc - 1 == seg_start + (E + G) * (1 + n_polls) - 1) begin
                    m_active = 1'b0;
                    if (m_to_pending) m_timeout = 1'b1;
                end
            end else if (mq.size() != 0) begin
                it        = mq.pop_front();
                m_active  = 1'b1;
                seg_start = cyc;
                m_rs      = it.rs;
                m_wdata   = it.data;
                m_nbusy   = it.nbusy;
                if (it.nbusy >= PLIM) begin
                    n_polls      = PLIM;
                    m_to_pending = 1'b1;
                end else begin
                    n_polls      = it.nbusy + 1;
                    m_to_pending = 1'b0;
                end
            end
            if (accept) begin
                it.rs    = bus.in_rs;
                it.data  = bus.in_data;
                it.nbusy = stim_nbusy;
                mq.push_back(it);
            end
        end
    endtask

    function automatic void exp_bus(output logic w, output logic r, output logic bt,
                                    output logic [1:0] a);
        int o;
        int p;
        int q;
        w  = 1'b0;
        r  = 1'b0;
        bt = 1'b0;
        a  = 2'b00;
        if (m_active) begin
            o = cyc - seg_start;
            if (o < E) begin
                w  = 1'b1;
                bt = (o == 0);
                a  = {m_rs, 1'b0};
            end else if (o >= E + G) begin
                p = (o - E - G) / (E + G);
                q = (o - E - G) % (E + G);
                if (p < n_polls && q < E) begin
                    r  = 1'b1;
                    bt = (q == 0);
                    a  = 2'b01;
                end
            end
        end
    endfunction

    function automatic logic [7:0] exp_rdata();
        int o;
        int p;
        if (m_active) begin
            o = cyc - seg_start - E - G;
            if (o >= 0) begin
                p = o / (E + G);
                return {(p < m_nbusy), 7'h2A};
            end
        end
        return 8'hC3;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        bus.avm_readdata = exp_rdata();
    endtask

    task automatic push(input logic rs, input logic [7:0] d, input int nb);
        bit done;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        stim_nbusy   = nb;
        for (int i = 0; i < BUDGET && !done; i++) begin
            done = (bus.in_ready === 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL push_accept at cycle %0d: got no in_ready, want accept of %0h", cyc, d);
        end
    endtask

    task automatic wait_idle(output int at);
        bit done;
        done = 1'b0;
        at   = -1;
        for (int i = 0; i < BUDGET && !done; i++) begin
            if (busy === 1'b0) begin
                done = 1'b1;
                at   = cyc;
            end else begin
                tick();
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wait_idle at cycle %0d: got busy=%0b, want 0", cyc, busy);
        end
    endtask

    always @(negedge clk) begin
        logic       ew;
        logic       er;
        logic       ebt;
        logic [1:0] ea;
        if (chk_en) begin
            exp_bus(ew, er, ebt, ea);
            chk("avm_write", bus.avm_write, ew);
            chk("avm_read", bus.avm_read, er);
            chk("avm_begintransfer", bus.avm_begintransfer, ebt);
            chk("avm_address", bus.avm_address, ea);
            chk("avm_writedata", bus.avm_writedata, m_wdata);
            chk("in_ready", bus.in_ready, mq.size() < DEPTH);
            chk("busy", busy, m_active || (mq.size() != 0));
            chk("timeout_err", timeout_err, m_timeout);
            chk("rd_wr_exclusive", bus.avm_write & bus.avm_read, 1'b0);
            if (bus.avm_write === 1'b1) mon_wr++;
            if (bus.avm_read === 1'b1) mon_rd++;
            if (bus.avm_begintransfer === 1'b1) begin
                mon_bt++;
                if (bus.avm_write === 1'b1) begin
                    mon_wr_bt_cyc = cyc;
                    mon_wr_addr   = bus.avm_address;
                    mon_wr_data   = bus.avm_writedata;
                    mon_wq.push_back(bus.avm_writedata);
                end
                if (bus.avm_read === 1'b1) mon_rd_bt_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int r0;
        int b0;
        int w1;
        int r1;
        int t0;
        int tidle;

        bus.in_valid     = 1'b0;
        bus.in_rs        = 1'b0;
        bus.in_data      = 8'h00;
        bus.avm_readdata = 8'hC3;
        reset            = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_writedata", bus.avm_writedata, 8'h00);
        chk("rst_address", bus.avm_address, 2'b00);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);

        // Single data byte, LCD ready on first poll
        w0 = mon_wr;
        r0 = mon_rd;
        b0 = mon_bt;
        push(1'b1, 8'h41, 0);
        t0 = cyc;
        wait_idle(tidle);
        chk("s1_wr_cycles", mon_wr - w0, 12);
        chk("s1_rd_cycles", mon_rd - r0, 12);
        chk("s1_bt_pulses", mon_bt - b0, 2);
        chk("s1_wr_start", mon_wr_bt_cyc - t0, 1);
        chk("s1_rd_start", mon_rd_bt_cyc - mon_wr_bt_cyc, 37);
        chk("s1_idle_at", tidle - t0, 75);
        chk("s1_addr", mon_wr_addr, 2'b10);
        chk("s1_data", mon_wr_data, 8'h41);

        // Back-to-back pushes fill the FIFO; one extra byte waits for a pop
        w0 = mon_wr;
        mon_wq.delete();
        for (int i = 0; i < 9; i++) push(1'(i % 2), 8'h10 + 8'(i), 0);
        chk("s2_full", bus.in_ready, 1'b0);
        push(1'b1, 8'h19, 0);
        wait_idle(tidle);
        chk("s2_wr_cycles", mon_wr - w0, 120);
        chk("s2_count", mon_wq.size(), 10);
        for (int i = 0; i < 10; i++) chk("s2_order", mon_wq[i], 8'h10 + 8'(i));

        // Three busy polls then ready: four polls, no timeout at the limit
        w0 = mon_wr;
        r0 = mon_rd;
        b0 = mon_bt;
        push(1'b0, 8'h38, 3);
        push(1'b1, 8'h42, 0);
        wait_idle(tidle);
        chk("s3_rd_cycles", mon_rd - r0, 60);
        chk("s3_wr_cycles", mon_wr - w0, 24);
        chk("s3_bt_pulses", mon_bt - b0, 7);
        chk("s3_no_timeout", timeout_err, 1'b0);
        chk("s3_last_data", mon_wr_data, 8'h42);

        // Busy flag stuck: timeout after POLL_LIMIT polls, next byte still sent
        w0 = mon_wr;
        r0 = mon_rd;
        push(1'b1, 8'h55, 1000);
        push(1'b1, 8'h56, 0);
        wait_idle(tidle);
        chk("s4_rd_cycles", mon_rd - r0, 60);
        chk("s4_wr_cycles", mon_wr - w0, 24);
        chk("s4_timeout", timeout_err, 1'b1);
        chk("s4_last_data", mon_wr_data, 8'h56);

        // Reset in the fifth write cycle with three bytes queued
        w0 = mon_wr;
        for (int i = 0; i < 4; i++) push(1'b1, 8'h60 + 8'(i), 0);
        for (int i = 0; i < 20 && cyc < mon_wr_bt_cyc + 4; i++) tick();
        chk("s5_in_write", bus.avm_write, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_write_dropped", bus.avm_write, 1'b0);
        chk("s5_busy", busy, 1'b0);
        chk("s5_timeout_clr", timeout_err, 1'b0);
        chk("s5_writedata_clr", bus.avm_writedata, 8'h00);
        w1 = mon_wr;
        r1 = mon_rd;
        chk("s5_partial_wr", w1 - w0, 5);
        repeat (150) tick();
        chk("s5_no_more_wr", mon_wr - w1, 0);
        chk("s5_no_more_rd", mon_rd - r1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lcd_write_sequencer.md
LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, entries in input FIFO (power of 2, 2..64).
REQ-002 Parameter: E_CYCLES, 12, clocks each LCD access (avm_write/avm_read) is held high.
REQ-003 Parameter: GAP_CYCLES, 25, idle clocks after every LCD access before the next one.
REQ-004 Parameter: POLL_LIMIT, 100000, maximum busy-flag reads per queued byte before timeout.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream byte offered.
REQ-008 in_ready  out  1  sequencer can accept a byte.
REQ-009 in_rs  in  1  0 = LCD command, 1 = LCD character data.
REQ-010 in_data  in  8  byte to send.
REQ-011 avm_address  out  2  to LCD slave; bit1 = RS, bit0 = RW.
REQ-012 avm_write  out  1  LCD write strobe (drives LCD_E downstream).
REQ-013 avm_read  out  1  LCD read strobe (drives LCD_E downstream).
REQ-014 avm_begintransfer  out  1  first cycle of each access.
REQ-015 avm_writedata  out  8  byte to LCD.
REQ-016 avm_readdata  in  8  LCD status; bit7 = busy flag.
REQ-017 busy  out  1  high while FIFO non-empty or FSM not IDLE.
REQ-018 timeout_err  out  1  sticky; set on busy-poll timeout.

Function
REQ-019 Handshake: byte accepted on a clk edge with in_valid && in_ready; in_ready = !fifo_full; in_valid may be held low indefinitely.
REQ-020 FIFO stores {in_rs, in_data}, first-in first-out; a byte pushed at edge t is poppable no earlier than edge t+1.
REQ-021 FSM states: IDLE, WR, WGAP, POLL, PGAP.
REQ-022 IDLE: if FIFO non-empty, pop head, latch it, go WR; otherwise stay IDLE.
REQ-023 WR: avm_write=1, avm_address={rs,0}, avm_writedata=latched byte for exactly E_CYCLES clocks; then WGAP.
REQ-024 WGAP: all strobes low for GAP_CYCLES clocks; then POLL; poll counter cleared.
REQ-025 POLL: avm_read=1, avm_address=2'b01 for E_CYCLES clocks; avm_readdata sampled on last POLL cycle; poll counter increments; then PGAP.
REQ-026 PGAP: strobes low for GAP_CYCLES clocks; then if sampled bit7=0 -> IDLE; if bit7=1 and poll count < POLL_LIMIT -> POLL; if bit7=1 and count = POLL_LIMIT -> set timeout_err, go IDLE (byte considered done).
REQ-027 avm_begintransfer high only in first cycle of WR and of each POLL.
REQ-028 avm_read and avm_write never high simultaneously; avm_address and avm_writedata stable for the whole access.
REQ-029 Outside WR, avm_writedata holds last value; avm_address = 2'b00 in IDLE/WGAP/PGAP.
REQ-030 Full FIFO: in_ready=0, no push; a pop in the same cycle raises in_ready the next cycle (no same-cycle bypass).
REQ-031 Throughput: minimum per byte = 2*E_CYCLES + 2*GAP_CYCLES + 1 clocks (one IDLE cycle).
REQ-032 timeout_err cleared only by reset; FSM continues with next FIFO entry after timeout.
REQ-033 Internal counters sized for their parameter max; no wrap before reaching limit.

Reset
REQ-034 While reset=1 at a clk edge: FSM -> IDLE, FIFO emptied, counters 0, timeout_err=0.
REQ-035 Outputs after reset: avm_write=0, avm_read=0, avm_begintransfer=0, avm_address=2'b00, avm_writedata=8'h00, busy=0, in_ready=1.
REQ-036 Reset mid-access drops the strobe the following cycle; in-flight and queued bytes discarded.

Verification
REQ-037 Push {rs=1,0x41}, readdata bit7=0 -> write 12 cycles addr 2'b10 data 0x41, 25 idle, one read 12 cycles addr 2'b01, IDLE at cycle 75, busy low.
REQ-038 Push 9 bytes back-to-back with FIFO_DEPTH=8 -> in_ready low after 8th accept (until first pop); all 9 emitted in order.
REQ-039 readdata bit7=1 for 3 polls then 0 -> exactly 4 POLL accesses, then next byte.
REQ-040 POLL_LIMIT=4, bit7 stuck 1 -> 4 polls, timeout_err=1, next queued byte still written.
REQ-041 Assert reset during cycle 5 of WR with 3 queued -> strobes low next cycle, busy=0, no further accesses.
REQ-042 Every access: begintransfer single-cycle pulse, read/write mutually exclusive, address/data stable (assertion-checked).
